// File: rtl/adder_multiword_seq.sv
// adder_multiword_seq
//   Performs a WORDS*WIDTH-bit addition by streaming WIDTH-bit slices, LSW
//   first, through an external registered adder (1-cycle s/co latency).
//   Each slice takes two cycles: ISSUE presents the slice and CAPTURE stores
//   the registered result. Only one operation is in flight at a time.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   op_a, op_b, cin     : full-width operands and carry-in, latched on accept
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : full-width result and carry-out of the top slice
//   add_a/add_b/add_ci  : slice operands driven to the external adder
//   add_s/add_co        : registered sum/carry returned by the external adder
module adder_multiword_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*WORDS-1:0]   op_a,
  input  logic [WIDTH*WORDS-1:0]   op_b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*WORDS-1:0]   sum,
  output logic                     cout,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_ci,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_co
);

  localparam int              FULL   = WIDTH * WORDS;
  localparam int              KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [FULL-1:0]   a_q, a_d;
  logic [FULL-1:0]   b_q, b_d;
  logic [FULL-1:0]   sum_q, sum_d;
  logic              cin_q, cin_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [KW-1:0]     k_q, k_d;

  logic [WIDTH-1:0]  a_slice;
  logic [WIDTH-1:0]  b_slice;
  logic              ci_slice;
  logic              drive;

  always_comb begin
    a_slice  = a_q[k_q*WIDTH +: WIDTH];
    b_slice  = b_q[k_q*WIDTH +: WIDTH];
    // Slice 0 takes the external carry-in; later slices chain the carry
    // captured from the previous slice.
    ci_slice = (k_q == '0) ? cin_q : carry_q;

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    k_d      = k_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = cin;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // add_s/add_co here reflect the operands presented during ISSUE;
        // the adder is only ever sampled in this state, so a result left
        // over from an aborted operation cannot be picked up.
        sum_d[k_q*WIDTH +: WIDTH] = add_s;
        carry_d = add_co;
        if (k_q == K_LAST) begin
          cout_d  = add_co;
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ISSUE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

  // Adder operands stay constant across ISSUE and CAPTURE of a slice and
  // are forced to zero whenever no slice is in flight.
  assign drive     = (state_q == ISSUE) || (state_q == CAPTURE);
  assign add_a     = drive ? a_slice  : '0;
  assign add_b     = drive ? b_slice  : '0;
  assign add_ci    = drive ? ci_slice : 1'b0;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_adder_multiword_seq.sv
module tb_adder_multiword_seq;

  localparam int W    = 32;
  localparam int N    = 4;
  localparam int WIDE = W * N;

  typedef logic [WIDE:0] val_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [WIDE-1:0] op_a = '0;
  logic [WIDE-1:0] op_b = '0;
  logic            cin = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [WIDE-1:0] sum;
  logic            cout;
  logic [W-1:0]    add_a, add_b;
  logic            add_ci;
  logic [W-1:0]    add_s = '0;
  logic            add_co = 1'b0;

  always #5 clk = ~clk;

  adder_multiword_seq #(.WIDTH(W), .WORDS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co)
  );

  // External registered 32-bit adder (no reset, so stale results persist).
  always @(posedge clk) begin
    {add_co, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input val_t act, input val_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 = waiting for operands, 1 = working (cnt cycles since accept),
  // 2 = result pending.
  int              m_phase = 0;
  int              m_cnt = 0;
  logic [WIDE-1:0] m_a = '0, m_b = '0;
  logic            m_ci = 1'b0;
  val_t            m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase <= 1;
          m_cnt   <= 0;
          m_a     <= op_a;
          m_b     <= op_b;
          m_ci    <= cin;
          m_res   <= {1'b0, op_a} + {1'b0, op_b} + val_t'(cin);
        end
        1: if (m_cnt == 2*N-1) m_phase <= 2; else m_cnt <= m_cnt + 1;
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Carry entering slice k, from the arithmetic sum of the lower k*W bits.
  function automatic logic carry_into(input int k);
    val_t m, t;
    if (k == 0) return m_ci;
    m = (val_t'(1) << (k*W)) - val_t'(1);
    t = ({1'b0, m_a} & m) + ({1'b0, m_b} & m) + val_t'(m_ci);
    return t[k*W];
  endfunction

  always @(negedge clk) begin
    int k;
    k = m_cnt / 2;
    chk("in_ready", val_t'(in_ready), val_t'(m_phase == 0));
    chk("out_valid", val_t'(out_valid), val_t'(m_phase == 2));
    if (m_phase == 1) begin
      chk("add_a", val_t'(add_a), val_t'(m_a[k*W +: W]));
      chk("add_b", val_t'(add_b), val_t'(m_b[k*W +: W]));
      chk("add_ci", val_t'(add_ci), val_t'(carry_into(k)));
      if ((m_cnt % 2) == 0 && m_cnt >= 2)
        chk("sum_slice", val_t'(sum[(k-1)*W +: W]), val_t'(m_res[(k-1)*W +: W]));
    end else begin
      chk("add_idle", val_t'({add_a, add_b, add_ci}), '0);
    end
    if (m_phase == 2) begin
      chk("sum", val_t'(sum), val_t'(m_res[WIDE-1:0]));
      chk("cout", val_t'(cout), val_t'(m_res[WIDE]));
    end
  end

  // ---------------- transfer monitor ----------------
  int   cyc = 0;
  val_t res_q[$];
  int   acc_q[$];
  int   hs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (rst_n && out_valid && out_ready) begin
      res_q.push_back({cout, sum});
      hs_q.push_back(cyc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b, input logic c);
    bit ok;
    ok = 0;
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1;
        step();
        break;
      end
      step();
    end
    in_valid = 1'b0;
    chk("accept_wait", val_t'(ok), val_t'(1));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("valid_wait", val_t'(out_valid), val_t'(1));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] ci_seen;
    logic [WIDE-1:0] held;
    int n;

    // Reset state
    #1;
    chk("rst_in_ready", val_t'(in_ready), val_t'(1));
    chk("rst_out_valid", val_t'(out_valid), val_t'(0));
    chk("rst_sum_cout", val_t'({cout, sum}), '0);
    chk("rst_add", val_t'({add_a, add_b, add_ci}), '0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Carry ripple with latency and per-slice carry-in
    ci_seen = '0;
    send(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0);
    for (int j = 0; j < 2*N; j++) begin
      if ((j % 2) == 0) ci_seen[j/2] = add_ci;
      if (j == 2*N-1) chk("lat_early", val_t'(out_valid), val_t'(0));
      step();
    end
    chk("lat_8", val_t'(out_valid), val_t'(1));
    chk("ripple_ci", val_t'(ci_seen), val_t'(4'b1110));
    chk("ripple_sum", val_t'(sum), val_t'(128'h00000001_00000000_00000000_00000000));
    chk("ripple_cout", val_t'(cout), val_t'(0));

    // Backpressure on that result; a pulsed request must be ignored
    held = sum;
    for (int j = 0; j < 5; j++) begin
      if (j == 2) begin
        op_a = 128'h1234; op_b = 128'h5678; cin = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk("bp_valid", val_t'(out_valid), val_t'(1));
      chk("bp_ready", val_t'(in_ready), val_t'(0));
      chk("bp_sum", val_t'({cout, sum}), val_t'({1'b0, held}));
      step();
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_drop", val_t'(out_valid), val_t'(0));
    chk("bp_idle", val_t'(in_ready), val_t'(1));
    chk("bp_accepts", val_t'(acc_q.size()), val_t'(1));
    chk("bp_outputs", val_t'(res_q.size()), val_t'(1));
    if (res_q.size() > 0)
      chk("bp_result", res_q[0], {1'b0, 128'h00000001_00000000_00000000_00000000});
    res_q.delete(); acc_q.delete(); hs_q.delete();

    // Full overflow
    send('1, '0, 1'b1);
    chk("ovf_ci0", val_t'(add_ci), val_t'(1));
    wait_valid();
    chk("ovf_sum", val_t'(sum), '0);
    chk("ovf_cout", val_t'(cout), val_t'(1));
    release_out();

    // Reset during CAPTURE of slice 1
    send(128'hDEADBEEF_01234567_89ABCDEF_FFFFFFFF, 128'h00000001_00000001_00000001_00000001, 1'b0);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", val_t'(in_ready), val_t'(1));
    chk("mid_rst_valid", val_t'(out_valid), val_t'(0));
    chk("mid_rst_sum", val_t'({cout, sum}), '0);
    chk("mid_rst_add", val_t'({add_a, add_b, add_ci}), '0);
    step(); step();
    rst_n = 1'b1;
    res_q.delete();
    n = 0;
    for (int j = 0; j < 12; j++) begin
      if (out_valid) n++;
      step();
    end
    chk("mid_rst_no_result", val_t'(n), '0);
    send(128'd5, 128'd7, 1'b1);
    wait_valid();
    chk("post_rst_sum", val_t'(sum), val_t'(13));
    chk("post_rst_cout", val_t'(cout), val_t'(0));
    release_out();
    res_q.delete(); acc_q.delete(); hs_q.delete();

    // Back-to-back with out_ready tied high and in_valid held
    out_ready = 1'b1;
    op_a = 128'h1_00000000; op_b = 128'hFFFFFFFF; cin = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    step();
    op_a = 128'h80000000_00000000_00000000_00000000;
    op_b = 128'h80000000_00000000_00000000_00000000;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (res_q.size() < 2 && n < 40) begin step(); n++; end
    out_ready = 1'b0;
    chk("b2b_outputs", val_t'(res_q.size()), val_t'(2));
    chk("b2b_accepts", val_t'(acc_q.size()), val_t'(2));
    if (res_q.size() >= 2) begin
      chk("b2b_first", res_q[0], val_t'(129'h0_1_FFFFFFFF));
      chk("b2b_second", res_q[1], {1'b1, 128'h0});
    end
    if (acc_q.size() >= 2 && hs_q.size() >= 1)
      chk("b2b_gap", val_t'(acc_q[1] - hs_q[0]), val_t'(1));

    step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/adder_multiword_seq.md
Name: adder_multiword_seq

Overview:
- Wide-operand sequencer placed directly upstream and downstream of the team's 32-bit registered dataflow adder (1-cycle registered s/co).
- Accepts a WORDS×WIDTH-bit addition over a valid/ready handshake.
- Feeds the adder one WIDTH-bit slice at a time, LSW first, chaining each slice's carry into the next slice.
- Collects the registered s/co slices into a full-width result, then presents the result on a valid/ready output handshake.

Parameters:
WIDTH, 32, slice width; must equal the attached adder's width.
WORDS, 4, number of slices per operation (≥2); the full operand width is WIDTH*WORDS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  block can accept an operation.
op_a  input  WIDTH*WORDS  operand A.
op_b  input  WIDTH*WORDS  operand B.
cin  input  1  carry-in to slice 0.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH*WORDS  result.
cout  output  1  carry-out of the top slice.
add_a  output  WIDTH  slice A to the adder.
add_b  output  WIDTH  slice B to the adder.
add_ci  output  1  slice carry-in to the adder.
add_s  input  WIDTH  registered adder sum, 1-cycle latency.
add_co  input  1  registered adder carry, 1-cycle latency.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared immediately on rst_n=0.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0.
  - add_a=0, add_b=0, add_ci=0.
  - Slice index=0, carry register=0.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- in_ready is high exactly in IDLE.
- IDLE→ISSUE: on an edge with in_valid&&in_ready.
  - op_a, op_b and cin are latched.
  - Slice index k=0.
  - Input changes after this edge are ignored.
- ISSUE (1 cycle): drive the adder with:
  - add_a=A[k*WIDTH+:WIDTH]
  - add_b=B[k*WIDTH+:WIDTH]
  - add_ci = (k==0) ? latched cin : carry register
  - Next state is CAPTURE.
- CAPTURE (1 cycle):
  - Hold add_a, add_b and add_ci unchanged from ISSUE.
  - At the end of the cycle, store add_s into sum[k*WIDTH+:WIDTH] and add_co into the carry register.
  - If k==WORDS-1: set cout=add_co, go to DONE.
  - Otherwise: k←k+1, go to ISSUE.
- add_a, add_b and add_ci are 0 in IDLE and DONE.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_ready=1 at an edge: out_valid←0, go to IDLE.
  - out_valid stays high indefinitely while out_ready=0.
  - in_valid is ignored.
- Latency: out_valid rises exactly 2*WORDS cycles after the accepting edge (8 cycles at the defaults).
- Throughput: at most one operation per 2*WORDS+2 cycles. No overlap of operations.
- sum partial slices may be visible before DONE. They are only qualified by out_valid.
- Arithmetic: the result is the modulo-2^(WIDTH*WORDS) sum of A+B+cin. cout is the true carry-out; no signed overflow flag is produced.
- Reset mid-operation:
  - The operation is aborted and no result is emitted.
  - in_ready=1 one cycle after rst_n deasserts.
  - A stale add_s/add_co from the adder is never captured.
- Both in_valid and out_ready high in DONE: only the output transfer occurs. The input is accepted on a later edge, from IDLE.

Test Plan:
- Carry ripple: A=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, cin=0 → sum=0x00000001_00000000_00000000_00000000, cout=0, out_valid rises 8 cycles after accept. add_ci per slice = 0,1,1,1.
- Full overflow: A=all-ones, B=0, cin=1 → sum=0, cout=1. add_ci for slice 0 equals 1.
- Backpressure: result ready with out_ready=0 for 5 cycles → out_valid, sum and cout stable, in_ready=0. A pulsed in_valid with new operands is not accepted. Raising out_ready → out_valid drops next edge and in_ready=1.
- Reset mid-op: assert rst_n=0 during CAPTURE of slice 1 → outputs are immediately at reset values. No out_valid follows. The next op A=5, B=7, cin=1 yields sum=13, cout=0.
- Back-to-back: out_ready tied 1, in_valid held high with two operations (A=0x1_00000000, B=0xFFFFFFFF; then A=B=0x80000000_00000000_00000000_00000000) → first result 0x1_FFFFFFFF, cout=0. Second result 0, cout=1. The second accept occurs the cycle after the first output handshake.
- Adder-interface check: in every CAPTURE cycle, the stored slice equals the bench model's 1-cycle-delayed add_a+add_b+add_ci. add_a and add_b are unchanged between ISSUE and CAPTURE.
